int_reservation_station: RTL and testbench

//  Unified reservation station between rename/dispatch and the issue unit. Holds

---
 rtl/rs_pkg.sv | 49 ++++
 rtl/int_reservation_station_if.sv | 45 ++++
 rtl/rs_age_select.sv | 72 +++++++
 rtl/int_reservation_station.sv | 164 ++++++++++++++++
 tb/tb_int_reservation_station.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Shared types and sizing for the integer reservation station.
// Contents:
//   - sizing constants: NUM_PHYS_REGS, RS_ENTRIES, ISSUE_WIDTH, DISPATCH_WIDTH, NUM_CDB
//   - derived widths: PREG_BITS (physical tag), IDX_BITS (slot index)
//   - rs_payload_t : everything the issue unit needs once an op is selected
//   - rs_entry_t   : payload plus operand tags and operand-ready flags
package rs_pkg;

  localparam int NUM_PHYS_REGS  = 64;
  localparam int RS_ENTRIES     = 16;
  localparam int ISSUE_WIDTH    = 4;
  localparam int DISPATCH_WIDTH = 2;
  localparam int NUM_CDB        = 2;

  localparam int PREG_BITS = $clog2(NUM_PHYS_REGS);
  localparam int IDX_BITS  = $clog2(RS_ENTRIES);

  typedef struct packed {
    logic [PREG_BITS-1:0] prd;
    logic [3:0]           alu_control;
    logic                 alu_src;
    logic [31:0]          imm;
    logic [4:0]           shamt;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 mem_write;
    logic                 mem_read;
    logic                 branch;
    logic [31:0]          pc;
    logic [31:0]          pc_plus_4;
    logic [31:0]          branch_target;
    logic [31:0]          jump_target;
    logic [2:0]           branch_type;
    logic [31:0]          predicted_target;
    logic                 predicted_taken;
    logic [6:0]           rob_idx;
    logic [31:0]          src1;
    logic [31:0]          src2;
  } rs_payload_t;

  typedef struct packed {
    rs_payload_t          payload;
    logic [PREG_BITS-1:0] tag1;
    logic [PREG_BITS-1:0] tag2;
    logic                 rdy1;
    logic                 rdy2;
  } rs_entry_t;

endpackage

// File: rtl/int_reservation_station_if.sv
// Bundle of the dispatch, CDB, issue and flush signals of the reservation station.
// Modports:
//   slave  - the reservation station itself
//   master - the surrounding pipeline (rename/dispatch, CDB, issue unit)
// Signals:
//   disp_valid/disp_entry/disp_ready : dispatch lanes, lane 0 is older
//   cdb_valid/cdb_prd/cdb_value      : wakeup broadcasts
//   issue_valid/issue_entry/issue_idx: oldest-first ready candidates
//   issue_ack                        : per-candidate acceptance
//   flush                            : squash everything held
//
// Handshakes: dispatch lanes transfer on a clock edge where disp_valid[l] and
// disp_ready are both high and flush is low; disp_ready depends only on registered
// state, and all valid lanes are accepted together. A candidate transfers on an edge
// where issue_valid[k] and issue_ack[k] are both high and flush is low; issue_valid
// depends only on registered state, so issue_ack may be derived from it in the same
// cycle. An ack against a low issue_valid has no effect.
interface int_reservation_station_if import rs_pkg::*; ();

  logic [DISPATCH_WIDTH-1:0] disp_valid;
  rs_entry_t                 disp_entry [DISPATCH_WIDTH];
  logic                      disp_ready;

  logic [NUM_CDB-1:0]        cdb_valid;
  logic [PREG_BITS-1:0]      cdb_prd    [NUM_CDB];
  logic [31:0]               cdb_value  [NUM_CDB];

  logic [ISSUE_WIDTH-1:0]    issue_valid;
  rs_payload_t               issue_entry [ISSUE_WIDTH];
  logic [IDX_BITS-1:0]       issue_idx   [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0]    issue_ack;

  logic                      flush;

  modport slave (
    input  disp_valid, disp_entry, cdb_valid, cdb_prd, cdb_value, issue_ack, flush,
    output disp_ready, issue_valid, issue_entry, issue_idx
  );

  modport master (
    output disp_valid, disp_entry, cdb_valid, cdb_prd, cdb_value, issue_ack, flush,
    input  disp_ready, issue_valid, issue_entry, issue_idx
  );

endinterface

// File: rtl/rs_age_select.sv
// Age matrix and oldest-first select for the reservation station.
// age_q[i][j] = 1 means slot j is older than slot i. A ready slot's rank is the
// number of ready slots older than it; rank k drives candidate k.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   wr_en_i        : one bit per slot written this edge
//   wr_row_i       : new age row for each written slot
//   ready_i        : per-slot ready (valid and both operands present)
//   issue_valid_o  : candidate k filled
//   issue_idx_o    : slot driving candidate k (0 when unfilled)
module rs_age_select #(
  parameter int RS_ENTRIES  = 16,
  parameter int ISSUE_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RS_ENTRIES-1:0]         wr_en_i,
  input  logic [RS_ENTRIES-1:0]         wr_row_i [RS_ENTRIES],
  input  logic [RS_ENTRIES-1:0]         ready_i,
  output logic [ISSUE_WIDTH-1:0]        issue_valid_o,
  output logic [$clog2(RS_ENTRIES)-1:0] issue_idx_o [ISSUE_WIDTH]
);

  localparam int IDX_BITS  = $clog2(RS_ENTRIES);
  localparam int RANK_BITS = $clog2(RS_ENTRIES + 1);

  logic [RS_ENTRIES-1:0] age_q [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] age_d [RS_ENTRIES];
  logic [RANK_BITS-1:0]  rank  [RS_ENTRIES];

  // A freshly written slot is younger than everything: its column is cleared in
  // every surviving row, and its own row is replaced wholesale.
  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      age_d[i] = wr_en_i[i] ? wr_row_i[i] : (age_q[i] & ~wr_en_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_ENTRIES; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) age_q[i] <= age_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      rank[i] = '0;
      for (int j = 0; j < RS_ENTRIES; j++) begin
        rank[i] = rank[i] + RANK_BITS'(age_q[i][j] & ready_i[j]);
      end
    end
  end

  // Ranks of ready slots are distinct, so at most one slot matches each k.
  always_comb begin
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      issue_valid_o[k] = 1'b0;
      issue_idx_o[k]   = '0;
    end
    for (int i = 0; i < RS_ENTRIES; i++) begin
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (ready_i[i] && (rank[i] == RANK_BITS'(k))) begin
          issue_valid_o[k] = 1'b1;
          issue_idx_o[k]   = IDX_BITS'(i);
        end
      end
    end
  end

endmodule

// File: rtl/int_reservation_station.sv
// Unified integer reservation station between rename/dispatch and issue.
// Holds renamed ops until both operands are captured (at dispatch or from the CDB),
// then presents up to ISSUE_WIDTH ready ops per cycle, oldest first.
// Ports:
//   clk   : clock
//   rst   : asynchronous reset, active low
//   rs_if : slave side of int_reservation_station_if (dispatch, CDB, issue, flush)
module int_reservation_station import rs_pkg::*; (
  input logic                      clk,
  input logic                      rst,
  int_reservation_station_if.slave rs_if
);

  localparam int CNT_BITS = $clog2(RS_ENTRIES + 1);

  logic [RS_ENTRIES-1:0]     valid_q, valid_d;
  rs_entry_t                 slot_q [RS_ENTRIES];
  rs_entry_t                 slot_d [RS_ENTRIES];

  logic [CNT_BITS-1:0]       free_cnt;
  logic                      disp_ready;
  logic [DISPATCH_WIDTH-1:0] lane_we;
  logic [IDX_BITS-1:0]       lane_slot [DISPATCH_WIDTH];

  logic [RS_ENTRIES-1:0]     ready;
  logic [RS_ENTRIES-1:0]     wr_en;
  logic [RS_ENTRIES-1:0]     wr_row [RS_ENTRIES];
  logic [ISSUE_WIDTH-1:0]    cand_valid;
  logic [IDX_BITS-1:0]       cand_idx [ISSUE_WIDTH];

  // Capture any still-missing operand from the CDB. Buses are scanned high to low
  // so the lowest matching bus is applied last and wins.
  function automatic rs_entry_t capture(input rs_entry_t e);
    rs_entry_t r;
    r = e;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (rs_if.cdb_valid[c]) begin
        if (!e.rdy1 && (rs_if.cdb_prd[c] == e.tag1)) begin
          r.rdy1         = 1'b1;
          r.payload.src1 = rs_if.cdb_value[c];
        end
        if (!e.rdy2 && (rs_if.cdb_prd[c] == e.tag2)) begin
          r.rdy2         = 1'b1;
          r.payload.src2 = rs_if.cdb_value[c];
        end
      end
    end
    return r;
  endfunction

  // Slots freed by this cycle's acks are deliberately not counted.
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      free_cnt = free_cnt + CNT_BITS'(~valid_q[i]);
    end
    disp_ready = (free_cnt >= CNT_BITS'(DISPATCH_WIDTH));
  end

  // Each accepted lane takes the lowest slot not already held or claimed by an
  // older lane.
  always_comb begin
    logic [RS_ENTRIES-1:0] taken;
    logic                  found;
    taken   = valid_q;
    found   = 1'b0;
    lane_we = '0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      lane_slot[l] = '0;
      if (rs_if.disp_valid[l] && disp_ready && !rs_if.flush) begin
        lane_we[l] = 1'b1;
        found      = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
          if (!found && !taken[i]) begin
            found        = 1'b1;
            lane_slot[l] = IDX_BITS'(i);
          end
        end
        taken[lane_slot[l]] = 1'b1;
      end
    end
  end

  // New age rows: everything held now, plus the slots of older lanes this cycle.
  always_comb begin
    logic [RS_ENTRIES-1:0] row_acc;
    row_acc = valid_q;
    wr_en   = '0;
    for (int i = 0; i < RS_ENTRIES; i++) wr_row[i] = '0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      if (lane_we[l]) begin
        wr_en[lane_slot[l]]  = 1'b1;
        wr_row[lane_slot[l]] = row_acc;
        row_acc[lane_slot[l]] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      slot_d[i] = valid_q[i] ? capture(slot_q[i]) : slot_q[i];
    end
    if (rs_if.flush) begin
      valid_d = '0;
    end else begin
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (rs_if.issue_ack[k] && cand_valid[k]) valid_d[cand_idx[k]] = 1'b0;
      end
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
        if (lane_we[l]) begin
          valid_d[lane_slot[l]] = 1'b1;
          slot_d[lane_slot[l]]  = capture(rs_if.disp_entry[l]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  // Slot contents are only observed through valid, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_ENTRIES; i++) slot_q[i] <= slot_d[i];
  end

  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      ready[i] = valid_q[i] & slot_q[i].rdy1 & slot_q[i].rdy2;
    end
  end

  rs_age_select #(
    .RS_ENTRIES  (RS_ENTRIES),
    .ISSUE_WIDTH (ISSUE_WIDTH)
  ) u_age_select (
    .clk           (clk),
    .rst           (rst),
    .wr_en_i       (wr_en),
    .wr_row_i      (wr_row),
    .ready_i       (ready),
    .issue_valid_o (cand_valid),
    .issue_idx_o   (cand_idx)
  );

  assign rs_if.disp_ready = disp_ready;

  always_comb begin
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      rs_if.issue_valid[k] = cand_valid[k];
      rs_if.issue_idx[k]   = cand_valid[k] ? cand_idx[k] : '0;
      rs_if.issue_entry[k] = cand_valid[k] ? slot_q[cand_idx[k]].payload : '0;
    end
  end

  // There is no overflow storage: a dispatch offered while not ready is lost.
  a_no_dispatch_when_full : assert property (
    @(posedge clk) disable iff (!rst)
    !((|rs_if.disp_valid) && !disp_ready && !rs_if.flush)
  );

endmodule

// File: tb/tb_int_reservation_station.sv
// Self-checking bench for int_reservation_station: directed scenarios followed by
// randomized traffic, all compared against an age-ordered queue model.
module tb_int_reservation_station;
  import rs_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_reservation_station_if rs_if ();

  int_reservation_station dut (
    .clk   (clk),
    .rst   (rst),
    .rs_if (rs_if)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int          slot;
    logic [6:0]  rob;
    logic [31:0] pc;
    logic [5:0]  tag1;
    logic [5:0]  tag2;
    bit          rdy1;
    bit          rdy2;
    logic [31:0] src1;
    logic [31:0] src2;
  } mop_t;

  mop_t exp_q[$];   // held ops, oldest first
  int   n_checks;
  int   n_errors;

  // driver-side copies of the inputs for the coming edge
  logic [DISPATCH_WIDTH-1:0] d_valid;
  rs_entry_t                 d_e   [DISPATCH_WIDTH];
  logic [NUM_CDB-1:0]        d_cv;
  logic [PREG_BITS-1:0]      d_prd [NUM_CDB];
  logic [31:0]               d_val [NUM_CDB];
  logic [ISSUE_WIDTH-1:0]    d_ack;
  logic                      d_flush;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_free();
    return RS_ENTRIES - exp_q.size();
  endfunction

  // Oldest ready ops, up to ISSUE_WIDTH; pos holds their queue positions.
  function automatic int get_cands(output int pos [ISSUE_WIDTH]);
    int n;
    n = 0;
    for (int k = 0; k < ISSUE_WIDTH; k++) pos[k] = -1;
    foreach (exp_q[i]) begin
      if (exp_q[i].rdy1 && exp_q[i].rdy2 && n < ISSUE_WIDTH) begin
        pos[n] = i;
        n++;
      end
    end
    return n;
  endfunction

  // Missing operand takes the value from the lowest-numbered matching bus.
  function automatic mop_t wake(input mop_t m);
    mop_t r;
    bit   d1, d2;
    r  = m;
    d1 = m.rdy1;
    d2 = m.rdy2;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (d_cv[c]) begin
        if (!d1 && d_prd[c] == m.tag1) begin r.rdy1 = 1; r.src1 = d_val[c]; d1 = 1; end
        if (!d2 && d_prd[c] == m.tag2) begin r.rdy2 = 1; r.src2 = d_val[c]; d2 = 1; end
      end
    end
    return r;
  endfunction

  task automatic model_step();
    int              pos [ISSUE_WIDTH];
    int              n, free0, s;
    bit [RS_ENTRIES-1:0] occ;
    int              acked[$];
    mop_t            m;
    n     = get_cands(pos);
    free0 = model_free();
    occ   = '0;
    foreach (exp_q[i]) occ[exp_q[i].slot] = 1'b1;
    if (d_flush) begin
      exp_q.delete();
      return;
    end
    for (int k = 0; k < n; k++) if (d_ack[k]) acked.push_back(exp_q[pos[k]].slot);
    foreach (exp_q[i]) exp_q[i] = wake(exp_q[i]);
    foreach (acked[a]) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i].slot == acked[a]) begin exp_q.delete(i); break; end
      end
    end
    if (free0 >= DISPATCH_WIDTH) begin
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
        if (d_valid[l]) begin
          s = -1;
          for (int i = RS_ENTRIES - 1; i >= 0; i--) if (!occ[i]) s = i;
          occ[s] = 1'b1;
          m.slot = s;
          m.rob  = d_e[l].payload.rob_idx;
          m.pc   = d_e[l].payload.pc;
          m.tag1 = d_e[l].tag1;
          m.tag2 = d_e[l].tag2;
          m.rdy1 = d_e[l].rdy1;
          m.rdy2 = d_e[l].rdy2;
          m.src1 = d_e[l].payload.src1;
          m.src2 = d_e[l].payload.src2;
          exp_q.push_back(wake(m));
        end
      end
    end
  endtask

  task automatic check_outputs();
    int         pos [ISSUE_WIDTH];
    int         n;
    logic [3:0] ev;
    n  = get_cands(pos);
    ev = '0;
    for (int k = 0; k < n; k++) ev[k] = 1'b1;
    check_eq("disp_ready", rs_if.disp_ready, model_free() >= DISPATCH_WIDTH);
    check_eq("issue_valid", rs_if.issue_valid, ev);
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (k < n) begin
        check_eq($sformatf("cand%0d_idx", k), rs_if.issue_idx[k], exp_q[pos[k]].slot);
        check_eq($sformatf("cand%0d_rob", k), rs_if.issue_entry[k].rob_idx, exp_q[pos[k]].rob);
        check_eq($sformatf("cand%0d_pc", k), rs_if.issue_entry[k].pc, exp_q[pos[k]].pc);
        check_eq($sformatf("cand%0d_src1", k), rs_if.issue_entry[k].src1, exp_q[pos[k]].src1);
        check_eq($sformatf("cand%0d_src2", k), rs_if.issue_entry[k].src2, exp_q[pos[k]].src2);
      end else begin
        check_eq($sformatf("cand%0d_idx_empty", k), rs_if.issue_idx[k], 0);
        check_eq($sformatf("cand%0d_entry_empty", k), rs_if.issue_entry[k] != '0, 0);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_drive();
    d_valid = '0;
    d_cv    = '0;
    d_ack   = '0;
    d_flush = 1'b0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) d_e[l] = '0;
    for (int c = 0; c < NUM_CDB; c++) begin d_prd[c] = '0; d_val[c] = '0; end
  endtask

  function automatic rs_entry_t make_op(input logic [6:0] rob, input bit r1, input logic [5:0] t1,
                                        input bit r2, input logic [5:0] t2);
    rs_entry_t e;
    e                 = '0;
    e.payload.rob_idx = rob;
    e.payload.pc      = $urandom;
    e.payload.imm     = $urandom;
    e.payload.prd     = PREG_BITS'($urandom);
    e.payload.src1    = $urandom;
    e.payload.src2    = $urandom;
    e.tag1            = t1;
    e.tag2            = t2;
    e.rdy1            = r1;
    e.rdy2            = r2;
    return e;
  endfunction

  // One clock: check current outputs, present inputs, advance model and DUT.
  task automatic tick();
    check_outputs();
    if (!d_flush && model_free() < DISPATCH_WIDTH) d_valid = '0;
    rs_if.disp_valid = d_valid;
    rs_if.cdb_valid  = d_cv;
    rs_if.issue_ack  = d_ack;
    rs_if.flush      = d_flush;
    for (int l = 0; l < DISPATCH_WIDTH; l++) rs_if.disp_entry[l] = d_e[l];
    for (int c = 0; c < NUM_CDB; c++) begin
      rs_if.cdb_prd[c]   = d_prd[c];
      rs_if.cdb_value[c] = d_val[c];
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    idle_drive();
  endtask

  task automatic apply_idle_to_dut();
    rs_if.disp_valid = '0;
    rs_if.cdb_valid  = '0;
    rs_if.issue_ack  = '0;
    rs_if.flush      = 1'b0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) rs_if.disp_entry[l] = '0;
    for (int c = 0; c < NUM_CDB; c++) begin rs_if.cdb_prd[c] = '0; rs_if.cdb_value[c] = '0; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_drive();
    apply_idle_to_dut();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_disp_ready", rs_if.disp_ready, 1);
    check_eq("rst_issue_valid", rs_if.issue_valid, 0);
    check_eq("rst_issue_idx0", rs_if.issue_idx[0], 0);
    check_eq("rst_entry0", rs_if.issue_entry[0] != '0, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: two ready ops issue together, oldest first
    d_valid = 2'b11;
    d_e[0]  = make_op(7'd3, 1, 6'd0, 1, 6'd0);
    d_e[1]  = make_op(7'd4, 1, 6'd0, 1, 6'd0);
    tick();
    check_eq("t1_valid", rs_if.issue_valid, 4'b0011);
    check_eq("t1_rob0", rs_if.issue_entry[0].rob_idx, 3);
    check_eq("t1_rob1", rs_if.issue_entry[1].rob_idx, 4);
    d_ack = 4'b0011;
    tick();
    check_eq("t1_freed", rs_if.issue_valid, 0);

    // 2: wakeup from the CDB one cycle after dispatch
    d_valid = 2'b01;
    d_e[0]  = make_op(7'd10, 0, 6'd12, 1, 6'd0);
    tick();
    check_eq("t2_pending", rs_if.issue_valid, 0);
    d_cv     = 2'b01;
    d_prd[0] = 6'd12;
    d_val[0] = 32'hDEAD;
    tick();
    check_eq("t2_woken", rs_if.issue_valid[0], 1);
    check_eq("t2_src1", rs_if.issue_entry[0].src1, 32'hDEAD);
    d_ack = 4'b0001;
    tick();

    // 3: same-cycle dispatch bypass
    d_valid  = 2'b01;
    d_e[0]   = make_op(7'd11, 1, 6'd0, 0, 6'd7);
    d_cv     = 2'b01;
    d_prd[0] = 6'd7;
    d_val[0] = 32'd5;
    tick();
    check_eq("t3_ready", rs_if.issue_valid[0], 1);
    check_eq("t3_src2", rs_if.issue_entry[0].src2, 32'd5);
    d_ack = 4'b0001;
    tick();

    // 4: fill, then partial acks re-rank
    for (int c = 0; c < 8; c++) begin
      d_valid = 2'b11;
      d_e[0]  = make_op(7'(20 + 2 * c), 1, 6'd0, 1, 6'd0);
      d_e[1]  = make_op(7'(21 + 2 * c), 1, 6'd0, 1, 6'd0);
      tick();
    end
    check_eq("t4_full16", rs_if.disp_ready, 0);
    check_eq("t4_rob0", rs_if.issue_entry[0].rob_idx, 20);
    d_ack = 4'b0001;
    tick();
    check_eq("t4_full15", rs_if.disp_ready, 0);
    d_ack = 4'b0101;
    tick();
    check_eq("t4_rerank0", rs_if.issue_entry[0].rob_idx, 22);
    check_eq("t4_rerank1", rs_if.issue_entry[1].rob_idx, 24);
    check_eq("t4_rerank2", rs_if.issue_entry[2].rob_idx, 25);
    check_eq("t4_rerank3", rs_if.issue_entry[3].rob_idx, 26);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      d_ack = 4'b1111;
      tick();
    end
    check_eq("t4_drained", rs_if.issue_valid, 0);

    // 5: an older op waking up displaces the youngest candidate
    d_valid = 2'b01;
    d_e[0]  = make_op(7'd40, 0, 6'd20, 1, 6'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      d_valid = 2'b11;
      d_e[0]  = make_op(7'(41 + 2 * c), 1, 6'd0, 1, 6'd0);
      d_e[1]  = make_op(7'(42 + 2 * c), 1, 6'd0, 1, 6'd0);
      tick();
    end
    check_eq("t5_before3", rs_if.issue_entry[3].rob_idx, 44);
    d_cv     = 2'b01;
    d_prd[0] = 6'd20;
    d_val[0] = 32'h1234;
    tick();
    check_eq("t5_cand0", rs_if.issue_entry[0].rob_idx, 40);
    check_eq("t5_cand0_src1", rs_if.issue_entry[0].src1, 32'h1234);
    check_eq("t5_cand3", rs_if.issue_entry[3].rob_idx, 43);

    // 6: flush wins over dispatch and acks
    d_valid = 2'b11;
    d_e[0]  = make_op(7'd50, 1, 6'd0, 1, 6'd0);
    d_e[1]  = make_op(7'd51, 1, 6'd0, 1, 6'd0);
    d_ack   = 4'b1111;
    d_flush = 1'b1;
    tick();
    check_eq("t6_valid", rs_if.issue_valid, 0);
    check_eq("t6_disp_ready", rs_if.disp_ready, 1);
    tick();
    check_eq("t6_retained", rs_if.issue_valid, 0);

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      d_flush = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) != 0) begin
        d_valid = DISPATCH_WIDTH'($urandom_range(0, 3));
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
          d_e[l] = make_op(7'($urandom), $urandom_range(0, 1) == 1, 6'($urandom_range(0, 15)),
                           $urandom_range(0, 1) == 1, 6'($urandom_range(0, 15)));
        end
      end
      d_cv     = NUM_CDB'($urandom_range(0, 3));
      d_prd[0] = 6'($urandom_range(0, 15));
      d_prd[1] = 6'($urandom_range(0, 15));
      if (d_prd[1] == d_prd[0]) d_prd[1] = d_prd[0] + 6'd1;
      d_val[0] = $urandom;
      d_val[1] = $urandom;
      d_ack    = ISSUE_WIDTH'($urandom_range(0, 15));
      tick();
    end
    check_outputs();

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
